// File: rtl/clock_pkg.sv
// Shared definitions for the clock time path and the alarm comparator:
// field widths, field limits, mode encodings and time_out bit positions.
package clock_pkg;

    localparam int FIELD_W  = 6;
    localparam int TIME_W   = 3 * FIELD_W;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int SEC_MAX  = 59;

    // time_out layout: {hour, min, sec}
    localparam int SEC_LSB  = 0;
    localparam int MIN_LSB  = SEC_LSB + FIELD_W;
    localparam int HOUR_LSB = MIN_LSB + FIELD_W;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } mode_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) field counter; carry flags the increment that wraps MAX back to 0.
module mod_counter
    import clock_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic               clk_tc,
    input  logic               clear,
    input  logic               inc,
    output logic [FIELD_W-1:0] value,
    output logic               carry
);

    logic at_max;

    assign at_max = (value == FIELD_W'(MAX));
    assign carry  = inc && at_max;

    always_ff @(posedge clk_tc) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (clear) begin
            value <= '0;
        end else if (inc) begin
            value <= at_max ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/time_counter.sv
// Time-of-day counter with a prescaled seconds tick and a button-driven
// set mode that walks hour -> minute -> second before returning to RUN.
module time_counter
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 3
) (
    input  logic              clk_tc,
    input  logic              reset,
    input  logic              mode_btn,
    input  logic              inc_btn,
    output logic [TIME_W-1:0] time_out,
    output logic [1:0]        set_mode,
    output logic              sec_pulse
);

    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    mode_t              state;
    logic [PRE_W-1:0]   prescaler;
    logic               mode_q;
    logic               inc_q;
    logic               mode_edge;
    logic               inc_edge;
    logic               tick;
    logic [FIELD_W-1:0] hour;
    logic [FIELD_W-1:0] min;
    logic [FIELD_W-1:0] sec;
    logic               sec_inc;
    logic               min_inc;
    logic               hour_inc;
    logic               sec_carry;
    logic               min_carry;
    logic               unused_day_wrap;

    // A mode press wins over a coincident inc press, which is dropped.
    assign mode_edge = mode_btn && !mode_q;
    assign inc_edge  = inc_btn && !inc_q && !mode_edge;
    assign tick      = (state == RUN) && (prescaler == PRE_LAST);

    // Carries ripple only on a RUN tick; set-mode increments touch one field.
    assign sec_inc  = tick || (inc_edge && state == SET_SEC);
    assign min_inc  = (tick && sec_carry) || (inc_edge && state == SET_MIN);
    assign hour_inc = (tick && sec_carry && min_carry) || (inc_edge && state == SET_HOUR);

    mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk_tc (clk_tc),
        .clear  (reset),
        .inc    (sec_inc),
        .value  (sec),
        .carry  (sec_carry)
    );

    mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk_tc (clk_tc),
        .clear  (reset),
        .inc    (min_inc),
        .value  (min),
        .carry  (min_carry)
    );

    mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk_tc (clk_tc),
        .clear  (reset),
        .inc    (hour_inc),
        .value  (hour),
        .carry  (unused_day_wrap)
    );

    assign time_out = {hour, min, sec};
    assign set_mode = state;

    always_ff @(posedge clk_tc) begin
        // NOTE: button history loads even during reset, so a button held across release gives no edge.
        mode_q <= mode_btn;
        inc_q  <= inc_btn;

        if (reset) begin
            state     <= RUN;
            prescaler <= '0;
            sec_pulse <= 1'b0;
        end else begin
            sec_pulse <= tick;

            if (state != RUN || tick) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + 1'b1;
            end

            case (state)
                RUN:      if (mode_edge) state <= SET_HOUR;
                SET_HOUR: if (mode_edge) state <= SET_MIN;
                SET_MIN:  if (mode_edge) state <= SET_SEC;
                SET_SEC:  if (mode_edge) state <= RUN;
                default:  state <= RUN;
            endcase
        end
    end

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 3, clk_tc cycles per second (one second per 3 cycles of the ~2.98 Hz divided clock).
REQ-002 SHALL provide port clk_tc  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port mode_btn  input  1  mode-advance button, already synchronous and debounced.
REQ-005 SHALL provide port inc_btn  input  1  field-increment button, already synchronous and debounced.
REQ-006 SHALL provide port time_out  output  18  {hour[17:12], min[11:6], sec[5:0]}, unsigned binary, registered; this is the clock time consumed by the alarm comparator.
REQ-007 SHALL provide port set_mode  output  2  current state: 0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC.
REQ-008 SHALL provide port sec_pulse  output  1  one-cycle pulse on each cycle in which sec advances in RUN.

Function
REQ-009 SHALL keep prescaler counting 0..TICK_DIV-1, wrapping to 0; tick is asserted when prescaler==TICK_DIV-1 and state==RUN.
REQ-010 SHALL hold prescaler at 0 in every SET state.
REQ-011 SHALL, on tick, increment sec; sec 59->0 carries to min; min 59->0 carries to hour; hour 23->0; 23:59:59 -> 00:00:00 in one cycle.
REQ-012 SHALL update time_out and assert sec_pulse at the same clock edge at which the tick is evaluated (zero added latency).
REQ-013 SHALL detect a button press as a rising edge: btn==1 and btn_q==0, where btn_q is the button value registered on the previous cycle.
REQ-014 SHALL advance on a mode_btn edge RUN->SET_HOUR->SET_MIN->SET_SEC->RUN, updating at the edge where the press is first sampled.
REQ-015 SHALL not advance time in SET states; time_out changes only through inc_btn.
REQ-016 SHALL, on an inc_btn edge in a SET state, increment only the selected field, wrapping hour 23->0 and min/sec 59->0, with no carry into other fields.
REQ-017 SHALL ignore inc_btn edges in RUN.
REQ-018 SHALL give mode_btn priority: if both edges occur in the same cycle, the state advances and the inc edge is discarded.
REQ-019 SHALL restart counting on SET_SEC->RUN with prescaler=0, so the first tick occurs TICK_DIV cycles after entering RUN.
REQ-020 SHALL generate one edge per press, never auto-repeating while a button is held.
REQ-021 SHALL decode any unreachable state encoding as RUN on the next cycle.

Reset
REQ-022 SHALL, on reset sampled high, set time_out=0 (00:00:00), set_mode=RUN, sec_pulse=0 and prescaler=0.
REQ-023 SHALL load btn_q with the current button values during reset, so a button held across reset release produces no edge.
REQ-024 SHALL let reset override every other event, including reset asserted mid-SET or coincident with a tick or edge.

Structure
REQ-025 SHALL place the following in shared package clock_pkg, also used by the alarm path: field width (6), HOUR_MAX (23), MIN_MAX/SEC_MAX (59), the state encodings, and the time_out bit-field positions.
REQ-026 SHALL implement each field with sub-module mod_counter (parameter MAX; inputs inc, clear; outputs value and carry on MAX->0), instantiated three times.

Verification (TICK_DIV=3)
REQ-027 SHALL verify reset then 3 cycles -> time_out=00:00:01 and sec_pulse high for exactly 1 cycle; after 180 cycles -> 00:01:00.
REQ-028 SHALL verify: set 23:59:59 via SET states, return to RUN, wait 3 cycles -> 00:00:00, and sec_pulse asserted on the wrap cycle.
REQ-029 SHALL verify one mode press -> set_mode=1; 25 inc presses -> hour=1; min/sec unchanged; prescaler held, with no tick over 20 cycles.
REQ-030 SHALL verify that in SET_MIN with min=10, simultaneous mode+inc edges -> set_mode=3 and min=10.
REQ-031 SHALL verify that mode_btn held high through reset release and for 5 further cycles -> set_mode stays 0.
REQ-032 SHALL verify that reset asserted in SET_MIN at 12:34:00 -> next cycle 00:00:00, set_mode=0; first tick 3 cycles after reset drops.
